// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
//
// Sequential unsigned integer divider using the restoring (shift-subtract-
// restore) algorithm. One quotient bit is produced per clock, so a result is
// available N+1 edges after the accepting start edge, flagged by a one-cycle
// done pulse. Quotient and remainder are registered and held until the next
// result is loaded.
//
// Parameters:
//   N            operand width in bits (N >= 2)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request pulse; operands sampled when start=1 and idle
//   dividend     unsigned dividend, sampled with start
//   divisor      unsigned divisor, sampled with start
//   quotient     unsigned quotient, registered, held until next result
//   remainder    unsigned remainder, registered, held until next result
//   busy         high while a division is in progress
//   done         one-cycle pulse when quotient/remainder become valid
//   div_by_zero  divide-by-zero flag
//
// Optional build macro:
//   RESTORING_DIVIDER_DIVZERO_CHECK_EN
//     Defined     : a start with divisor=0 bypasses the iterative path and
//                   returns quotient=all ones, remainder=dividend on the next
//                   cycle with div_by_zero=1. The flag holds until the next
//                   accepted start or reset.
//     Not defined : div_by_zero is tied low and divisor=0 runs through the
//                   normal N-cycle iteration.
// -----------------------------------------------------------------------------
module restoring_divider #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t         r_state;

    // Partial remainder. The algorithm nominally keeps A in N+1 bits, but
    // after every restore/accept step A < M <= 2^N-1, so its top bit is always
    // zero; only the N low bits are stored. The extra bit reappears in the
    // shifted value used for the trial subtraction.
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_q;
    logic [N-1:0]   r_m;
    logic [CW-1:0]  r_cnt;

    logic [N-1:0]   r_quotient;
    logic [N-1:0]   r_remainder;
    logic           r_busy;
    logic           r_done;

    logic [N:0]     w_shift_a;
    logic [N:0]     w_trial;
    logic           w_neg;
    logic [N-1:0]   w_a_next;
    logic [N-1:0]   w_q_next;
    logic           w_accept;
    logic           w_zero_div;

    // -------------------------------------------------------------------------
    // One restoring iteration: shift {A,Q} left, trial-subtract M from A,
    // keep the old (shifted) A when the trial went negative.
    // -------------------------------------------------------------------------
    always_comb begin
        w_shift_a = {r_a, r_q[N-1]};
        w_trial   = w_shift_a - {1'b0, r_m};
        w_neg     = w_trial[N];
        w_a_next  = w_neg ? w_shift_a[N-1:0] : w_trial[N-1:0];
        w_q_next  = {r_q[N-2:0], ~w_neg};
    end

    assign w_accept = (r_state == S_IDLE) && start;

`ifdef RESTORING_DIVIDER_DIVZERO_CHECK_EN
    assign w_zero_div = (divisor == '0);
`else
    assign w_zero_div = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Control FSM and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_q         <= '0;
            r_m         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_zero_div) begin
                            // Short-circuit result; the FSM stays idle.
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_done      <= 1'b1;
                        end else begin
                            r_m     <= divisor;
                            r_q     <= dividend;
                            r_a     <= '0;
                            r_cnt   <= CNT_INIT;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    // start is intentionally ignored here.
                    r_a   <= w_a_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_a_next;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Divide-by-zero flag
    // -------------------------------------------------------------------------
`ifdef RESTORING_DIVIDER_DIVZERO_CHECK_EN
    logic r_div_by_zero;

    // Every accepted start rewrites the flag, so a non-zero divisor clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_div_by_zero <= w_zero_div;
        end
    end

    assign div_by_zero = r_div_by_zero;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
    assign div_by_zero     = 1'b0;
`endif

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int unsigned n_checks;
    int unsigned n_fails;

    restoring_divider #(.N(N)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait for done. edges counts the capture edge
    // as edge 1; busy_cyc counts sampled cycles with busy high before done.
    task automatic run_op(input logic [N-1:0] dd, input logic [N-1:0] dv,
                          output int unsigned edges, output int unsigned busy_cyc);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        tick();
        start    = 1'b0;
        edges    = 1;
        busy_cyc = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cyc++;
            tick();
            edges++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    int unsigned edges;
    int unsigned bcyc;

    logic [N-1:0] b2b_dd [3] = '{4'd14, 4'd13, 4'd9};
    logic [N-1:0] b2b_dv [3] = '{4'd3,  4'd5,  4'd2};
    logic [N-1:0] b2b_q  [3] = '{4'd4,  4'd2,  4'd4};
    logic [N-1:0] b2b_r  [3] = '{4'd2,  4'd3,  4'd1};

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();

        // Reset state
        check("rst_q",    32'(quotient),    32'd0);
        check("rst_r",    32'(remainder),   32'd0);
        check("rst_busy", 32'(busy),        32'd0);
        check("rst_done", 32'(done),        32'd0);
        check("rst_dbz",  32'(div_by_zero), 32'd0);
        rst = 1'b0;
        tick();

        // 15/3 latency and busy window
        run_op(4'd15, 4'd3, edges, bcyc);
        check("lat_edges", edges,         32'd5);
        check("lat_busy",  bcyc,          32'd4);
        check("lat_q",     32'(quotient), 32'd5);
        check("lat_r",     32'(remainder),32'd0);
        check("done_busy", 32'(busy),     32'd0);
        tick();
        check("done_pulse", 32'(done),    32'd0);

        // Back-to-back with start coincident with done
        start    = 1'b1;
        dividend = b2b_dd[0];
        divisor  = b2b_dv[0];
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            edges = 1;
            while (!done && edges < 40) begin
                tick();
                edges++;
            end
            check("b2b_lat", edges, 32'd5);
            check("b2b_q", 32'(quotient),  32'(b2b_q[k]));
            check("b2b_r", 32'(remainder), 32'(b2b_r[k]));
            if (k < 2) begin
                start    = 1'b1;
                dividend = b2b_dd[k+1];
                divisor  = b2b_dv[k+1];
                tick();
                start = 1'b0;
                check("b2b_accept", 32'(busy), 32'd1);
            end
        end
        tick();

        // start during RUN is ignored
        start    = 1'b1;
        dividend = 4'd12;
        divisor  = 4'd5;
        tick();
        start = 1'b0;
        tick();
        check("hold_during_run", 32'(quotient), 32'd4);
        start    = 1'b1;
        dividend = 4'd8;
        divisor  = 4'd2;
        tick();
        start = 1'b0;
        edges = 3;
        while (!done && edges < 40) begin
            tick();
            edges++;
        end
        check("ign_lat", edges,           32'd5);
        check("ign_q",   32'(quotient),   32'd2);
        check("ign_r",   32'(remainder),  32'd2);
        tick();
        tick();
        tick();
        check("ign_idle_busy", 32'(busy),     32'd0);
        check("ign_hold_q",    32'(quotient), 32'd2);
        check("ign_hold_r",    32'(remainder),32'd2);

        // Divide by zero
        run_op(4'd7, 4'd0, edges, bcyc);
        check("dz_q", 32'(quotient),  32'd15);
        check("dz_r", 32'(remainder), 32'd7);
`ifdef RESTORING_DIVIDER_DIVZERO_CHECK_EN
        check("dz_lat", edges,            32'd1);
        check("dz_flag", 32'(div_by_zero), 32'd1);
        tick();
        check("dz_flag_hold", 32'(div_by_zero), 32'd1);
        run_op(4'd9, 4'd2, edges, bcyc);
        check("dz_clr_q",   32'(quotient),    32'd4);
        check("dz_clr_r",   32'(remainder),   32'd1);
        check("dz_clr_flag",32'(div_by_zero), 32'd0);
`else
        check("dz_lat", edges,             32'd5);
        check("dz_flag", 32'(div_by_zero), 32'd0);
`endif
        tick();

        // Reset two cycles into an operation
        start    = 1'b1;
        dividend = 4'd15;
        divisor  = 4'd3;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy),      32'd0);
        check("abort_done", 32'(done),      32'd0);
        check("abort_q",    32'(quotient),  32'd0);
        check("abort_r",    32'(remainder), 32'd0);
        bcyc = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) bcyc++;
            tick();
        end
        check("abort_quiet", bcyc, 32'd0);
        run_op(4'd9, 4'd2, edges, bcyc);
        check("abort_fresh_lat", edges,          32'd5);
        check("abort_fresh_q",   32'(quotient),  32'd4);
        check("abort_fresh_r",   32'(remainder), 32'd1);
        tick();

        // Exhaustive sweep over non-zero divisors
        for (int dd = 0; dd < 16; dd++) begin
            for (int dv = 1; dv < 16; dv++) begin
                run_op(4'(dd), 4'(dv), edges, bcyc);
                check("sweep_q", 32'(quotient),  32'(dd / dv));
                check("sweep_r", 32'(remainder), 32'(dd % dv));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned integer divider using the restoring (shift-subtract-restore) algorithm, one quotient bit per clock.
- Accepts a dividend/divisor pair on a start pulse and returns quotient and remainder after a fixed N-cycle latency, with a one-cycle done pulse.
- Intended as a small arithmetic helper next to a controller or datapath that tolerates multi-cycle latency.

Parameters:
- N, 4, operand width in bits; dividend, divisor, quotient and remainder are all N bits; N >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request pulse; operands are sampled on the clk edge where start=1 and the block is idle.
- dividend  input  N  unsigned dividend, sampled with start.
- divisor  input  N  unsigned divisor, sampled with start.
- quotient  output  N  unsigned quotient; registered; held until next accepted start.
- remainder  output  N  unsigned remainder; registered; held until next accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when quotient/remainder become valid.
- div_by_zero  output  1  divide-by-zero flag (see Optional Feature).

Behaviour:
- One clock (clk) and a synchronous active-high reset (rst); all state changes on the rising clk edge.
- Reset: state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; all internal registers cleared.
- States: IDLE, RUN. In IDLE: busy=0. On an edge with start=1, capture M=divisor, Q=dividend, A=0 (N+1 bits), counter=N, and go to RUN.
- RUN, each cycle:
  - Shift {A,Q} left by 1.
  - Compute T = A - {0,M} in N+1 bits.
  - If T is negative (MSB=1): keep A (restore) and set Q[0]=0. Otherwise A=T and Q[0]=1.
  - Decrement counter.
- Iteration that brings the counter to 0:
  - Load quotient=Q(final) and remainder=A[N-1:0].
  - Assert done=1 for exactly that following cycle; return to IDLE.
- Latency: done is high in the cycle after the N-th RUN edge, i.e. N+1 edges after the start edge, counting the capture edge. busy is high from the edge after capture until done is asserted, and is low during the done cycle.
- start during RUN is ignored; operands are not re-sampled and the current operation is unaffected.
- start in the same cycle as done, with the block back in IDLE, is accepted normally (back-to-back operation).
- Outputs quotient/remainder change only when done is asserted, or on reset.
- Result invariant for divisor != 0: dividend = quotient*divisor + remainder, with remainder < divisor.
- divisor=0 without the optional feature: the algorithm runs naturally, giving quotient = all ones, remainder = dividend, normal latency, div_by_zero=0.
- rst asserted mid-operation: abort immediately to the reset state; no done pulse; outputs cleared.
- rst has priority over start.

Optional Feature:
- Macro: RESTORING_DIVIDER_DIVZERO_CHECK_EN.
- Defined:
  - An accepted start with divisor=0 skips RUN.
  - On the next edge: quotient = all ones, remainder = dividend, div_by_zero=1, and done pulses (latency 1 cycle).
  - div_by_zero stays high until the next accepted start or reset, and is cleared on any accepted start with divisor != 0.
- Not defined: div_by_zero is tied to 0, and divisor=0 follows the normal N-cycle path described in Behaviour.

Test Plan:
- Reset, then start with 15/3 -> done exactly N+1 edges after the start edge (5 for N=4); quotient=5, remainder=0; busy high 4 cycles.
- Back-to-back 14/3, 13/5, 9/2, with start coincident with each done -> (4,2), (2,3), (4,1) in order, no lost operations.
- start pulsed again during RUN with different operands -> ignored; original result is delivered; outputs hold until the next accepted start.
- 7/0 -> without the macro: quotient=15, remainder=7 after the normal latency, div_by_zero=0. With the macro: same values after 1 cycle, div_by_zero=1; a following 9/2 clears the flag.
- rst asserted 2 cycles into a 15/3 operation -> busy=0, done never pulses, quotient=0, remainder=0; a fresh start afterwards yields the correct result.
- Exhaustive sweep of all dividend/divisor pairs with divisor != 0 (N=4) -> dividend = quotient*divisor + remainder and remainder < divisor for every pair.
